// File: rtl/addsub_arbiter.sv
// Round-robin arbiter between a Wishbone slave port and a logic-analyzer requester sharing one add/sub datapath.
// Optional datapath-wait abort is enabled by defining ADDSUB_ARB_TIMEOUT_EN.
module addsub_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        la_req_i,
  input  logic        la_sub_i,
  input  logic [31:0] la_operands_i,
  output logic        la_ack_o,
  output logic [31:0] la_result_o,
  output logic        dp_valid_o,
  output logic        dp_sub_o,
  output logic [15:0] dp_a_o,
  output logic [15:0] dp_b_o,
  input  logic        dp_ready_i,
  input  logic [31:0] dp_result_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  // Datapath handshake: dp_valid_o rises when a request is issued and stays high with
  // stable operands until the first rising edge where dp_ready_i is sampled high.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_la_q, gnt_la_d;
  logic        last_la_q, last_la_d;
  logic        ack_en_q, ack_en_d;
  logic        sub_q, sub_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic [31:0] la_res_q, la_res_d;

  logic wb_req;
  logic wb_sub;
  logic pick_la;
  logic sel_unused;

  assign wb_req     = wbs_cyc_i & wbs_stb_i;
  assign wb_sub     = wbs_we_i & wbs_sel_i[0];
  assign sel_unused = ^wbs_sel_i[3:1];
  // On a tie the requester that was not served last wins.
  assign pick_la    = la_req_i & (~wb_req | ~last_la_q);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

`ifdef ADDSUB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_la_d  = gnt_la_q;
    last_la_d = last_la_q;
    ack_en_d  = ack_en_q;
    sub_d     = sub_q;
    a_d       = a_q;
    b_d       = b_q;
    wb_dat_d  = wb_dat_q;
    la_res_d  = la_res_q;
`ifdef ADDSUB_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (wb_req || la_req_i) begin
          gnt_la_d  = pick_la;
          last_la_d = pick_la;
          ack_en_d  = 1'b1;
          sub_d     = pick_la ? la_sub_i : wb_sub;
          a_d       = pick_la ? la_operands_i[31:16] : wbs_dat_i[31:16];
          b_d       = pick_la ? la_operands_i[15:0] : wbs_dat_i[15:0];
          state_d   = ISSUE;
`ifdef ADDSUB_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      ISSUE: begin
        // A Wishbone master that walks away still gets its result, just no ack.
        if (!gnt_la_q && !wb_req) ack_en_d = 1'b0;
        if (dp_ready_i) begin
          if (gnt_la_q) la_res_d = dp_result_i;
          else          wb_dat_d = dp_result_i;
          state_d = RESP;
        end
`ifdef ADDSUB_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          if (gnt_la_q) la_res_d = 32'hFFFF_FFFF;
          else          wb_dat_d = 32'hFFFF_FFFF;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= IDLE;
      gnt_la_q  <= 1'b0;
      last_la_q <= 1'b1;
      ack_en_q  <= 1'b0;
      sub_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      wb_dat_q  <= '0;
      la_res_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_la_q  <= gnt_la_d;
      last_la_q <= last_la_d;
      ack_en_q  <= ack_en_d;
      sub_q     <= sub_d;
      a_q       <= a_d;
      b_q       <= b_d;
      wb_dat_q  <= wb_dat_d;
      la_res_q  <= la_res_d;
    end
  end

`ifdef ADDSUB_ARB_TIMEOUT_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign dp_valid_o  = (state_q == ISSUE);
  assign dp_sub_o    = sub_q;
  assign dp_a_o      = a_q;
  assign dp_b_o      = b_q;
  assign wbs_ack_o   = (state_q == RESP) & ~gnt_la_q & ack_en_q;
  assign la_ack_o    = (state_q == RESP) & gnt_la_q;
  assign wbs_dat_o   = wb_dat_q;
  assign la_result_o = la_res_q;
  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning datapath-wait cycles before abort (used only with ADDSUB_ARB_TIMEOUT_EN).
REQ-002 SHALL have port wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port wb_rst_i  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone slave request qualifiers.
REQ-005 SHALL have ports wbs_sel_i  in  4 and wbs_dat_i  in  32  byte selects and packed operands {A[31:16], B[15:0]}.
REQ-006 SHALL have ports wbs_ack_o  out  1 and wbs_dat_o  out  32  Wishbone acknowledge and result.
REQ-007 SHALL have ports la_req_i  in  1, la_sub_i  in  1, la_operands_i  in  32  logic-analyzer requester: level request, op select, packed {A, B}.
REQ-008 SHALL have ports la_ack_o  out  1 and la_result_o  out  32  LA acknowledge pulse and result.
REQ-009 SHALL have ports dp_valid_o  out  1, dp_sub_o  out  1, dp_a_o  out  16, dp_b_o  out  16  request to shared add/sub datapath.
REQ-010 SHALL have ports dp_ready_i  in  1 and dp_result_i  in  32  datapath completion and result.
REQ-011 SHALL have ports busy_o  out  1 (state != IDLE) and err_o  out  1 (sticky timeout flag).

Function
REQ-012 SHALL treat WB request as wbs_cyc_i & wbs_stb_i; WB op is subtract when wbs_we_i & wbs_sel_i[0], else add.
REQ-013 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE; states only change on wb_clk_i rising edge.
REQ-014 In IDLE with any request, SHALL grant one requester, latch op/A/B/grant id, and enter ISSUE next cycle.
REQ-015 SHALL arbitrate round-robin: on simultaneous WB and LA requests, grant the requester not granted last; after reset WB wins first.
REQ-016 In ISSUE SHALL hold dp_valid_o=1 with stable dp_sub_o/dp_a_o/dp_b_o until the cycle dp_ready_i=1 is sampled.
REQ-017 On dp_ready_i in ISSUE SHALL capture dp_result_i into the granted requester's result register and enter RESP.
REQ-018 In RESP SHALL assert the granted requester's ack (wbs_ack_o or la_ack_o) for exactly one cycle, then return to IDLE.
REQ-019 Minimum latency: request sampled at edge N, dp_valid_o high cycle N+1, ready in N+1, ack high cycle N+2.
REQ-020 If WB request drops while WB is granted (ISSUE), SHALL still complete the datapath transaction but SHALL NOT assert wbs_ack_o; wbs_dat_o still updates.
REQ-021 wbs_dat_o and la_result_o SHALL hold last captured value until next capture for that requester.
REQ-022 Requests arriving outside IDLE SHALL be held pending (level) and arbitrated at next IDLE; no requests are queued beyond the level.
REQ-023 dp_valid_o, wbs_ack_o, la_ack_o SHALL never be asserted in IDLE; both acks SHALL never be high together.

Reset
REQ-024 wb_rst_i=0 SHALL immediately force IDLE, dp_valid_o=0, dp_sub_o=0, dp_a_o=0, dp_b_o=0, wbs_ack_o=0, la_ack_o=0, wbs_dat_o=0, la_result_o=0, busy_o=0, err_o=0, last-grant=LA.
REQ-025 Reset mid-ISSUE SHALL abandon the transaction with no ack; first post-reset grant follows REQ-015.

Configuration
REQ-026 With ADDSUB_ARB_TIMEOUT_EN defined, SHALL count ISSUE cycles; after TIMEOUT cycles without dp_ready_i SHALL drop dp_valid_o, load result 32'hFFFF_FFFF, set err_o (sticky until reset), enter RESP and ack normally.
REQ-027 Without ADDSUB_ARB_TIMEOUT_EN, SHALL wait in ISSUE indefinitely; err_o tied 0; TIMEOUT unused.

Verification
REQ-028 WB write sel=4'h1, dat=32'h0009_0003, dp returns A-B with ready same cycle -> dp_sub_o=1, dp_a_o=9, dp_b_o=3, wbs_ack_o high cycle N+2, wbs_dat_o=32'h0000_0006.
REQ-029 WB and LA request same cycle after reset, both add 32'h0001_0002 -> WB granted first (ack, result 3), LA granted next, la_ack_o one cycle later; third simultaneous pair -> WB again.
REQ-030 dp_ready_i delayed 5 cycles -> dp_valid_o and operands stable 6 cycles, single ack, busy_o high throughout.
REQ-031 WB drops cyc during ISSUE -> no wbs_ack_o, wbs_dat_o updated, FSM returns to IDLE.
REQ-032 wb_rst_i low during ISSUE -> all outputs zero asynchronously, no ack; with ADDSUB_ARB_TIMEOUT_EN and TIMEOUT=16, ready never asserted -> ack after 16 ISSUE cycles, result 32'hFFFF_FFFF, err_o=1.
